// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared constants, FSM encoding and sizing helpers for the key conditioner.
`timescale 1ns/1ps
`default_nettype none

package key_cond_pkg;

  // Raw KEY pins pull low when pressed.
  localparam logic KEY_ACTIVE = 1'b0;

  // Default timing for a 50 MHz clock.
  localparam int DEF_N_KEYS          = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  typedef enum logic [1:0] {
    KC_IDLE   = 2'd0,
    KC_HELD   = 2'd1,
    KC_REPEAT = 2'd2
  } kc_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_cond_ch.sv
// key_cond_ch: one key channel -- synchronizer, debounce, press/release/repeat FSM.
`timescale 1ns/1ps
`default_nettype none

module key_cond_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic rpt_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  // One spare bit so the saturation value can never equal a terminal count.
  localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RCNT_SAT   = {RW{1'b1}};

  logic          sync1_q, sync2_q;
  logic          s;
  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  kc_state_e     state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          press_evt, release_evt;

  assign s = (sync2_q == KEY_ACTIVE);

  // deb_q leads level_q by one cycle; the counter compares against it so that
  // it restarts cleanly on the very cycle a change is accepted.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (s != deb_q) begin
      if (dcnt_q == DCNT_LAST) begin
        deb_d = s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  assign press_evt   = deb_q & ~level_q;
  assign release_evt = ~deb_q & level_q;

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    level_d   = deb_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      KC_IDLE: begin
        if (press_evt) begin
          state_d = KC_HELD;
          rcnt_d  = '0;
          press_d = 1'b1;
        end
      end
      KC_HELD: begin
        if (release_evt) begin
          state_d   = KC_IDLE;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else if (rpt_en && (rcnt_q == DELAY_LAST)) begin
          state_d  = KC_REPEAT;
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else if (rcnt_q != RCNT_SAT) begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      KC_REPEAT: begin
        if (release_evt) begin
          state_d   = KC_IDLE;
          rcnt_d    = '0;
          release_d = 1'b1;
        end else if (!rpt_en) begin
          // Parked at saturation: repeats stay off until the next press.
          state_d = KC_HELD;
          rcnt_d  = RCNT_SAT;
        end else if (rcnt_q == PER_LAST) begin
          rcnt_d   = '0;
          repeat_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = KC_IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= KC_IDLE;
      rcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule

`default_nettype wire

// File: rtl/key_cond.sv
// key_cond: N_KEYS independent debounced key channels with press/release/auto-repeat pulses.
`timescale 1ns/1ps
`default_nettype none

module key_cond
  import key_cond_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] rpt_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_cond_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw[i]),
      .rpt_en      (rpt_en[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_cond.sv
// tb_key_cond: directed scenarios plus random key activity against a windowed reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_key_cond;

  localparam int NK = 3;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] rpt_en = '0;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b1;

  key_cond #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_raw     (key_raw),
    .rpt_en      (rpt_en),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: a change is accepted at edge t when the DC raw samples
  // taken at edges t-DC-2 .. t-3 all disagree with the current level.
  // Repeats: RD edges after the press, then every RP, while rpt_en stays on.
  bit            m_hist [NK][DC+3];
  bit            m_lvl  [NK];
  int            m_age  [NK];
  bit            m_kill [NK];
  bit            m_stable;
  logic [NK-1:0] e_lvl = '0, e_pr = '0, e_rl = '0, e_rp = '0;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e_lvl = '0; e_pr = '0; e_rl = '0; e_rp = '0;
      for (int k = 0; k < NK; k++) begin
        for (int j = 0; j < DC + 3; j++) m_hist[k][j] = 1'b0;
        m_lvl[k] = 1'b0; m_age[k] = 0; m_kill[k] = 1'b0;
      end
    end else begin
      e_pr = '0; e_rl = '0; e_rp = '0;
      for (int k = 0; k < NK; k++) begin
        for (int j = DC + 2; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = (key_raw[k] == 1'b0);
        m_stable = 1'b1;
        for (int j = 3; j <= DC + 2; j++) if (m_hist[k][j] == m_lvl[k]) m_stable = 1'b0;
        if (m_stable) begin
          m_lvl[k] = !m_lvl[k];
          if (m_lvl[k]) begin
            e_pr[k] = 1'b1; m_age[k] = 0; m_kill[k] = 1'b0;
          end else begin
            e_rl[k] = 1'b1;
          end
        end else if (m_lvl[k]) begin
          m_age[k]++;
          if (m_age[k] >= RD) begin
            if (!rpt_en[k]) m_kill[k] = 1'b1;
            else if (!m_kill[k] && ((m_age[k] - RD) % RP == 0)) e_rp[k] = 1'b1;
          end
        end
        e_lvl[k] = m_lvl[k];
      end
    end
  end

  always begin
    @(negedge clk);
    if (chk_on) begin
      check_eq("level",   32'(key_level),   32'(e_lvl));
      check_eq("press",   32'(key_press),   32'(e_pr));
      check_eq("release", 32'(key_release), 32'(e_rl));
      check_eq("repeat",  32'(key_repeat),  32'(e_rp));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    key_raw = '1;
    for (int i = 0; i < n; i++) step();
  endtask

  int first_pr, first_rp, last_rp, rel_t, n_pr, n_rp, n_rl, n_rp_after;
  int hold [NK];

  initial begin
    repeat (3) step();
    check_eq("reset_outs", 32'({key_level, key_press, key_release, key_repeat}), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Clean press on key 0, driven right after edge 0.
    first_pr = -1; n_pr = 0;
    for (int t = 0; t < 14; t++) begin
      if (t > 0) step();
      if (t == 0) key_raw[0] = 1'b0;
      @(negedge clk);
      if (key_press[0]) begin n_pr++; if (first_pr < 0) first_pr = t; end
      if (t == 7) begin
        check_eq("clean_level", 32'(key_level), 32'b001);
        check_eq("clean_others", 32'(key_press[2:1]), 32'd0);
      end
    end
    check_eq("clean_press_cycle", 32'(first_pr), 32'd7);
    check_eq("clean_press_count", 32'(n_pr), 32'd1);
    idle(15);

    // Bounce on key 1: 20 cycles of 2-cycle toggling, then held low.
    n_pr = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      key_raw[1] = ((t / 2) % 2 == 1);
      @(negedge clk);
      if (key_press[1] || key_release[1]) n_pr++;
    end
    check_eq("bounce_quiet", 32'(n_pr), 32'd0);
    step();
    key_raw[1] = 1'b0;
    first_pr = -1; n_pr = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      @(negedge clk);
      if (key_press[1]) begin n_pr++; if (first_pr < 0) first_pr = c; end
    end
    check_eq("bounce_press_lat", 32'(first_pr), 32'(DC + 2));
    check_eq("bounce_press_count", 32'(n_pr), 32'd1);
    idle(15);

    // Auto-repeat on key 0; level held 30 cycles after the press.
    rpt_en = 3'b001;
    first_pr = -1; first_rp = -1; last_rp = -1; rel_t = -1; n_rp = 0; n_rl = 0; n_rp_after = 0;
    for (int t = 0; t < 55; t++) begin
      if (t > 0) step();
      if (t == 0) key_raw[0] = 1'b0;
      if (t == 30) key_raw[0] = 1'b1;
      @(negedge clk);
      if (key_press[0] && first_pr < 0) first_pr = t;
      if (key_release[0]) begin n_rl++; rel_t = t; end
      if (key_repeat[0]) begin
        if (rel_t >= 0) n_rp_after++;
        else begin n_rp++; if (first_rp < 0) first_rp = t; last_rp = t; end
      end
    end
    check_eq("rpt_first", 32'(first_rp - first_pr), 32'd10);
    check_eq("rpt_last", 32'(last_rp - first_pr), 32'd28);
    check_eq("rpt_count", 32'(n_rp), 32'd7);
    check_eq("rpt_release_at", 32'(rel_t - first_pr), 32'd30);
    check_eq("rpt_release_count", 32'(n_rl), 32'd1);
    check_eq("rpt_after_release", 32'(n_rp_after), 32'd0);
    idle(15);

    // Repeat disabled, key 2 held 40 cycles.
    rpt_en = 3'b000;
    n_pr = 0; n_rp = 0; n_rl = 0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) step();
      if (t == 0) key_raw[2] = 1'b0;
      if (t == 40) key_raw[2] = 1'b1;
      @(negedge clk);
      if (key_press[2]) n_pr++;
      if (key_repeat[2]) n_rp++;
      if (key_release[2]) n_rl++;
    end
    check_eq("norpt_press", 32'(n_pr), 32'd1);
    check_eq("norpt_repeat", 32'(n_rp), 32'd0);
    check_eq("norpt_release", 32'(n_rl), 32'd1);
    idle(15);

    // All three keys fall on the same edge.
    for (int t = 0; t < 10; t++) begin
      if (t > 0) step();
      if (t == 0) key_raw = 3'b000;
      @(negedge clk);
      if (t == 7) check_eq("simul_press", 32'(key_press), 32'b111);
    end
    idle(15);

    // Reset while key 0 is repeating; key stays held through reset release.
    rpt_en = 3'b001;
    n_rl = 0; first_pr = -1; n_rp = 0;
    for (int t = 0; t < 45; t++) begin
      if (t > 0) step();
      if (t == 0) key_raw[0] = 1'b0;
      if (t == 20) rst_n = 1'b0;
      if (t == 23) rst_n = 1'b1;
      @(negedge clk);
      if (t == 18) n_rp = int'(key_repeat[0]) + int'(dut.key_level[0]);
      if (t >= 20 && t < 23)
        check_eq("rst_mid_outs", 32'({key_level, key_press, key_release, key_repeat}), 32'd0);
      if (t >= 20 && key_release[0]) n_rl++;
      if (t >= 23 && key_press[0] && first_pr < 0) first_pr = t;
    end
    check_eq("rst_was_repeating", 32'(n_rp), 32'd1);
    check_eq("rst_fresh_press", 32'(first_pr - 23), 32'(DC + 3));
    check_eq("rst_no_release", 32'(n_rl), 32'd0);
    rpt_en = '0;
    idle(15);

    // Random activity: mix of bounces and real holds, occasional rpt_en/reset changes.
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int t = 0; t < 3000; t++) begin
      step();
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_raw[k] = ~key_raw[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 149) == 0) rpt_en = 3'($urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    idle(20);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
